// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: rotate req so the search starts after last, priority-encode, un-rotate.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [NUM_REQ-1:0] rot_s;
  logic [IW-1:0]      start_s;
  logic [IW-1:0]      off_s;

  // (a + b) mod NUM_REQ, valid for a, b < NUM_REQ.
  function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    s = (s >= NUM_REQ) ? s - NUM_REQ : s;
    return IW'(s);
  endfunction

  // Rotation, lowest-set-bit encode and index restore.
  always_comb begin
    start_s = (last == IW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot_s[i] = req[add_mod(start_s, i)];
    end
    off_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IW'(i) : off_s;
    end
    found = |req;
    idx   = add_mod(start_s, int'(off_s));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts of up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               ack,
  input  logic                             fifo_full,
  output logic                             fifo_wr,
  output logic [DATA_WIDTH-1:0]            fifo_din,
  output logic [idx_width(NUM_REQ)-1:0]    owner,
  output logic                             busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t                state_r, state_nx_s;
  logic [IW-1:0]         last_r, last_nx_s;
  logic [IW-1:0]         owner_r, owner_nx_s;
  logic [CW-1:0]         beat_cnt_r, beat_cnt_nx_s;
  logic                  pick_found_s;
  logic [IW-1:0]         pick_idx_s;
  logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req   (req),
    .last  (last_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign owner    = owner_r;
  assign busy     = (state_r == GRANT);
  assign fifo_din = data_arr_s[owner_r];

  // Next-state and write/ack decode; full is honoured in the same cycle so no beat is lost.
  always_comb begin
    state_nx_s    = state_r;
    last_nx_s     = last_r;
    owner_nx_s    = owner_r;
    beat_cnt_nx_s = beat_cnt_r;
    fifo_wr       = 1'b0;
    ack           = '0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          owner_nx_s    = pick_idx_s;
          last_nx_s     = pick_idx_s;
          beat_cnt_nx_s = '0;
          state_nx_s    = GRANT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      GRANT: begin
        if (!req[owner_r]) begin
          state_nx_s = IDLE;
        end else if (fifo_full) begin
          state_nx_s = GRANT;
        end else begin
          fifo_wr        = !rst;
          ack[owner_r]   = !rst;
          beat_cnt_nx_s  = beat_cnt_r + 1'b1;
          if (beat_cnt_r == CW'(MAX_BURST - 1)) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = GRANT;
          end
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_r     <= IW'(NUM_REQ - 1);
      owner_r    <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_nx_s;
      last_r     <= last_nx_s;
      owner_r    <= owner_nx_s;
      beat_cnt_r <= beat_cnt_nx_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic checked against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             fifo_full = 1'b0;
  logic [NR-1:0]    ack;
  logic             fifo_wr;
  logic [DW-1:0]    fifo_din;
  logic [IW-1:0]    owner;
  logic             busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .owner     (owner),
    .busy      (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: whether a burst is in progress, who owns it, beats so far, last winner.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = NR - 1;
  int m_beats = 0;

  logic          s_wr, s_busy;
  logic [NR-1:0] s_ack;
  logic [DW-1:0] s_din;
  logic [IW-1:0] s_owner;
  logic [DW-1:0] wq[$];
  bit            rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic void set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endfunction

  // One clock cycle: sample at negedge, compare with model, advance model and producers.
  task automatic step();
    logic          e_wr;
    logic [NR-1:0] e_ack;
    int            p;
    @(negedge clk);
    s_wr = fifo_wr; s_ack = ack; s_din = fifo_din; s_owner = owner; s_busy = busy;
    e_wr = 1'b0; e_ack = '0;
    if (!rst && m_busy && req[m_owner] && !fifo_full) begin
      e_wr = 1'b1;
      e_ack[m_owner] = 1'b1;
    end
    check("busy", s_busy, m_busy);
    check("owner", s_owner, m_owner);
    check("fifo_wr", s_wr, e_wr);
    check("ack", s_ack, e_ack);
    if (e_wr) begin
      check("fifo_din", s_din, req_data[m_owner*DW +: DW]);
      wq.push_back(s_din);
    end
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_last = NR - 1; m_beats = 0;
    end else if (!m_busy) begin
      p = m_pick(req, m_last);
      if (p >= 0) begin
        m_busy = 1'b1; m_owner = p; m_last = p; m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
    end else if (e_wr) begin
      m_beats++;
      if (m_beats == MB) m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (e_ack[i]) begin
        if (rand_mode && $urandom_range(1, 0) == 0) req[i] = 1'b0;
        else set_data(i, rand_mode ? DW'($urandom) : req_data[i*DW +: DW] + 8'd1);
      end else if (rand_mode && !req[i] && $urandom_range(9, 0) < 3) begin
        req[i] = 1'b1;
        set_data(i, DW'($urandom));
      end
    end
    if (rand_mode) begin
      fifo_full = ($urandom_range(3, 0) == 0);
      rst       = ($urandom_range(199, 0) == 0);
    end
  endtask

  task automatic do_reset();
    req = '0; fifo_full = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) step();
  endtask

  initial begin
    bit b1[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int sent;
    int n2;
    int n3;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();
    check("reset_busy", s_busy, 1'b0);
    check("reset_owner", s_owner, 2'd0);

    // Single requester, 6 beats
    sent = 0;
    set_data(1, 8'h10);
    req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      step();
      check("s1_busy", s_busy, b1[c]);
      check("s1_wr", s_wr, b1[c]);
      if (b1[c]) begin
        check("s1_din", s_din, 8'h10 + sent);
        sent++;
      end
      if (sent == 6) req = '0;
    end
    idle(3);

    // All four requesting continuously
    do_reset();
    for (int i = 0; i < NR; i++) set_data(i, DW'(i * 16));
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      step();
      check("s2_busy", s_busy, (c % 5) != 0);
      check("s2_wr", s_wr, (c % 5) != 0);
      if (c % 5 == 1) check("s2_owner", s_owner, (c / 5) % 4);
    end
    idle(2);

    // Full stall after beat 2
    do_reset();
    wq.delete();
    set_data(0, 8'hA0);
    req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      step();
      if (c >= 3 && c <= 5) begin
        check("s3_stall_wr", s_wr, 1'b0);
        check("s3_stall_ack", s_ack, 4'b0000);
        check("s3_stall_busy", s_busy, 1'b1);
      end
      if (wq.size() == 4) req = '0;
    end
    fifo_full = 1'b0;
    idle(2);
    check("s3_count", wq.size(), 4);
    for (int k = 0; k < 4 && k < wq.size(); k++) check("s3_order", wq[k], 8'hA0 + k);

    // Early release by requester 2 while 3 waits
    do_reset();
    wq.delete();
    set_data(2, 8'h20);
    set_data(3, 8'h30);
    req = 4'b1100;
    step();
    step();
    check("s4_owner2", s_owner, 2'd2);
    step();
    req[2] = 1'b0;
    step();
    check("s4_drop_busy", s_busy, 1'b1);
    check("s4_drop_wr", s_wr, 1'b0);
    step();
    check("s4_idle", s_busy, 1'b0);
    step();
    check("s4_owner3", s_owner, 2'd3);
    check("s4_wr3", s_wr, 1'b1);
    idle(3);
    n2 = 0; n3 = 0;
    foreach (wq[k]) begin
      if (wq[k][7:4] == 4'h2) n2++;
      if (wq[k][7:4] == 4'h3) n3++;
    end
    check("s4_req2_beats", n2, 2);
    check("s4_req3_beats", n3, 1);

    // Wrap-around from last = 2
    do_reset();
    set_data(2, 8'h50);
    req = 4'b0100;
    step();
    step();
    req = '0;
    step();
    step();
    set_data(0, 8'h60);
    req = 4'b0101;
    step();
    check("s5_arb_idle", s_busy, 1'b0);
    step();
    check("s5_owner0", s_owner, 2'd0);
    repeat (3) step();
    step();
    check("s5_between", s_busy, 1'b0);
    step();
    check("s5_owner2", s_owner, 2'd2);
    check("s5_busy2", s_busy, 1'b1);
    idle(3);

    // Reset mid-burst
    do_reset();
    set_data(0, 8'h70);
    set_data(1, 8'h80);
    req = 4'b0011;
    step();
    step();
    rst = 1'b1;
    step();
    check("s6_rst_wr", s_wr, 1'b0);
    check("s6_rst_ack", s_ack, 4'b0000);
    rst = 1'b0;
    step();
    check("s6_idle_busy", s_busy, 1'b0);
    check("s6_idle_owner", s_owner, 2'd0);
    step();
    check("s6_first_owner", s_owner, 2'd0);
    check("s6_first_busy", s_busy, 1'b1);
    idle(3);

    // Random traffic against the model
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    rst = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
